// File: rtl/bcd_dabble_digit.sv
// Double-dabble adjust for one BCD digit: values >= 5 get +3 so the
// following left shift carries correctly into the next decade.
// Ports:
//   digit       4-bit working BCD digit before the shift
//   adjusted_c  digit + 3 when digit >= 5, otherwise digit (combinational)
module bcd_dabble_digit (
    input  logic [3:0] digit,
    output logic [3:0] adjusted_c
);

    assign adjusted_c = (digit >= 4'd5) ? 4'(digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock, with a start/busy/done handshake. The result and overflow flag are
// held until the next conversion completes.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high; clears all state
//   start     conversion request, sampled only while idle
//   bin       binary operand, captured on the accepting edge
//   busy      high while a conversion is in progress
//   done      one-cycle pulse when bcd/overflow have just been updated
//   bcd       packed BCD result, digit 0 in [3:0]
//   overflow  value exceeded the digit capacity; valid with done, held
module bin2bcd_seq #(
    parameter int unsigned bin_width = 8,
    parameter int unsigned digits    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [bin_width-1:0]  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*digits-1:0]   bcd,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * digits;
    localparam int unsigned CNT_W = $clog2(bin_width + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]           state_q,    state_d;
    logic [bin_width-1:0] shift_q,    shift_d;
    logic [BCD_W-1:0]     work_q,     work_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic                 ovf_acc_q,  ovf_acc_d;
    logic                 busy_d;
    logic                 done_d;
    logic [BCD_W-1:0]     bcd_d;
    logic                 overflow_d;

    logic [BCD_W-1:0]     adj_c;
    logic [BCD_W-1:0]     shifted_c;
    logic                 exit_bit_c;

    // Per-digit add-3 adjust; digits are independent (no inter-digit carry).
    for (genvar g = 0; g < digits; g++) begin : g_digit
        bcd_dabble_digit u_digit (
            .digit      (work_q[4*g +: 4]),
            .adjusted_c (adj_c[4*g +: 4])
        );
    end

    // Operand MSB enters working bit 0; working MSB falls out as overflow.
    assign shifted_c  = {adj_c[BCD_W-2:0], shift_q[bin_width-1]};
    assign exit_bit_c = adj_c[BCD_W-1];

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        ovf_acc_d  = ovf_acc_q;
        busy_d     = busy;
        done_d     = 1'b0;
        bcd_d      = bcd;
        overflow_d = overflow;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    shift_d   = bin;
                    work_d    = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(bin_width);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                work_d    = shifted_c;
                shift_d   = shift_q << 1;
                ovf_acc_d = ovf_acc_q | exit_bit_c;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d      = shifted_c;
                    overflow_d = ovf_acc_q | exit_bit_c;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            busy      <= busy_d;
            done      <= done_d;
            bcd       <= bcd_d;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 3-digit and a 2-digit instance.
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset;

    logic        start_a, busy_a, done_a, overflow_a;
    logic [7:0]  bin_a;
    logic [11:0] bcd_a;

    logic        start_b, busy_b, done_b, overflow_b;
    logic [7:0]  bin_b;
    logic [7:0]  bcd_b;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.bin_width(8), .digits(3)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .start    (start_a),
        .bin      (bin_a),
        .busy     (busy_a),
        .done     (done_a),
        .bcd      (bcd_a),
        .overflow (overflow_a)
    );

    bin2bcd_seq #(.bin_width(8), .digits(2)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .start    (start_b),
        .bin      (bin_b),
        .busy     (busy_b),
        .done     (done_b),
        .bcd      (bcd_b),
        .overflow (overflow_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] cur_bcd(input bit sel);
        return sel ? {4'h0, bcd_b} : bcd_a;
    endfunction

    // Called at a negedge: requests a conversion, then steps edge by edge
    // until done (bounded), checking latency, busy length and held output.
    task automatic convert(input bit sel, input logic [7:0] v,
                           input logic [11:0] exp_bcd, input logic exp_ovf,
                           input string tag);
        logic [11:0] prev;
        int busy_n;
        int edge_n;
        bit seen;
        prev   = cur_bcd(sel);
        busy_n = 0;
        edge_n = -1;
        seen   = 1'b0;
        if (sel) begin start_b = 1'b1; bin_b = v; end
        else     begin start_a = 1'b1; bin_a = v; end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) begin start_a = 1'b0; start_b = 1'b0; end
            if (sel ? done_b : done_a) begin
                seen   = 1'b1;
                edge_n = i;
            end else begin
                if (sel ? busy_b : busy_a) busy_n++;
                chk({tag, "_hold"}, 32'(cur_bcd(sel)), 32'(prev));
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_done_edge"}, 32'(edge_n), 32'd8);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
        chk({tag, "_bcd"}, 32'(cur_bcd(sel)), 32'(exp_bcd));
        chk({tag, "_ovf"}, 32'(sel ? overflow_b : overflow_a), 32'(exp_ovf));
        chk({tag, "_busy_at_done"}, 32'(sel ? busy_b : busy_a), 32'd0);
    endtask

    initial begin
        int n;
        bit seen;
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        bin_a   = 8'd0;
        bin_b   = 8'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_bcd", 32'(bcd_a), 32'h000);
        chk("rst_ovf", 32'(overflow_a), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic conversions.
        convert(1'b0, 8'd0,   12'h000, 1'b0, "zero");
        @(negedge clk);
        chk("zero_done_pulse", 32'(done_a), 32'd0);
        convert(1'b0, 8'd255, 12'h255, 1'b0, "max");
        @(negedge clk);
        convert(1'b0, 8'd99,  12'h099, 1'b0, "n99");
        chk("n99_set_num", 32'(bcd_a[7:0]), 32'h99);
        @(negedge clk);

        // Start while busy is ignored; bin change has no effect.
        start_a = 1'b1;
        bin_a   = 8'd200;
        @(posedge clk);              // edge 0
        @(negedge clk);
        start_a = 1'b0;
        @(posedge clk);              // edge 1
        @(negedge clk);
        @(posedge clk);              // edge 2
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 8'd17;
        @(posedge clk);              // edge 3
        @(negedge clk);
        start_a = 1'b0;
        seen = 1'b0;
        n = 3;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (done_a) seen = 1'b1;
        end
        chk("ign_done_edge", 32'(n), 32'd8);
        chk("ign_bcd", 32'(bcd_a), 32'h200);
        @(negedge clk);
        chk("ign_no_second", 32'(busy_a), 32'd0);
        chk("ign_done_clear", 32'(done_a), 32'd0);

        // Back-to-back: restart in the done cycle.
        convert(1'b0, 8'd128, 12'h128, 1'b0, "b2b1");
        convert(1'b0, 8'd64,  12'h064, 1'b0, "b2b2");
        @(negedge clk);

        // Overflow on the 2-digit instance.
        convert(1'b1, 8'd100, 12'h000, 1'b1, "ovf100");
        @(negedge clk);
        chk("ovf_held", 32'(overflow_b), 32'd1);
        convert(1'b1, 8'd42,  12'h042, 1'b0, "ovf42");
        @(negedge clk);

        // Reset mid-conversion.
        start_a = 1'b1;
        bin_a   = 8'd255;
        @(posedge clk);              // edge 0
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_busy_pre", 32'(busy_a), 32'd1);
        chk("mid_bcd_pre", 32'(bcd_a), 32'h064);
        reset = 1'b1;
        #1;
        chk("mid_busy", 32'(busy_a), 32'd0);
        chk("mid_done", 32'(done_a), 32'd0);
        chk("mid_bcd", 32'(bcd_a), 32'h000);
        chk("mid_ovf_b", 32'(overflow_b), 32'd0);
        chk("mid_bcd_b", 32'(bcd_b), 32'h00);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
            if (i == 1) reset = 1'b0;
        end
        chk("mid_no_done", 32'(seen), 32'd0);
        convert(1'b0, 8'd7, 12'h007, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
It is the inverse of the BCD counters: it turns binary values (register contents, ALU results, switch inputs) into packed BCD.
Its output drives 7-segment display logic or the set_num load inputs of the BCD counters.
It uses a start/busy/done handshake and holds the result until the next conversion completes.

Parameters:
bin_width, 8, width of the binary input in bits (>= 1).
digits, 3, number of BCD output digits. The result is exact when 10^digits > 2^bin_width - 1; otherwise overflow can flag.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request a conversion of bin; sampled only while idle
bin  in  bin_width  binary operand, captured at the accepting edge
busy  out  1  high while a conversion is in progress
done  out  1  single-cycle pulse: bcd and overflow just updated
bcd  out  4*digits  packed BCD result, digit 0 in [3:0]; held between conversions
overflow  out  1  result exceeded digits capacity; valid with done, held until the next done

Behaviour:
- Reset values (asynchronous): state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal shift and bit-count registers 0.
- States: IDLE, SHIFT.
- IDLE:
  - busy=0.
  - On a rising edge with start=1: capture bin into the shift register, clear the working BCD register and the overflow accumulator, load bit count = bin_width, go to SHIFT.
  - done is cleared on any edge where a new completion does not occur.
- SHIFT, each edge:
  - Every working digit >= 5 gets +3 (4-bit add, no carry between digits).
  - Then {working, shift} shifts left 1; the shift-register MSB enters working bit 0.
  - The bit leaving working MSB ORs into the overflow accumulator.
  - Count decrements.
- Last SHIFT edge (count==1):
  - bcd <= adjusted-and-shifted working value.
  - overflow <= accumulator OR the current exiting bit.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start sampled at edge 0; done high in the cycle after edge bin_width; busy high in the cycles after edges 0..bin_width-1.
- start while busy: ignored; bin changes while busy have no effect.
- start high in the done cycle: accepted; back-to-back throughput is one conversion per bin_width+1 cycles.
- bcd and overflow change only on a done edge or on reset. Partial results are never visible.
- Overflow case: the low digits equal the true value mod 10^digits. Each digit's adjust is independent, so no extra logic is needed.
- Reset mid-conversion: immediate abort to IDLE, all outputs 0, no done pulse.
- bin_width=1: single SHIFT cycle, done at edge 1.

Decomposition:
- No shared package; the only constant is the state encoding (1 bit), kept local.
- One natural combinational sub-module, bcd_dabble_digit: 4-bit in, outputs in + 3 when in >= 5, else in.
- Instantiated digits times with a generate loop.

Test Plan:
- bin_width=8, digits=3: start with bin=8'd0 -> done at edge 8, bcd=12'h000, overflow=0; busy high exactly 8 cycles.
- bin=8'd255 -> bcd=12'h255. bin=8'd99 -> bcd=12'h099, and bcd[7:0]=8'h99 loads correctly into a 2-digit BCD counter's set_num.
- Start at edge 0 with bin=8'd200, then start=1, bin=8'd17 at edge 3 -> the second request is ignored; done at edge 8 with bcd=12'h200 only.
- Start with bin=8'd128, then start again with bin=8'd64 during the done cycle -> first done shows 12'h128, second done 9 edges later shows 12'h064.
- digits=2, bin=8'd100 -> bcd=8'h00, overflow=1. Next conversion of 8'd42 -> bcd=8'h42, overflow=0.
- Start with bin=8'd255, assert reset at edge 4 -> busy, done, bcd and overflow go to 0 immediately, no done pulse; after reset release a new start with 8'd7 gives 12'h007.
